inst_fetch_pc_gen: RTL

Fetch-request front end for the dual-way fetch path. It owns the program counter and issues one 8-byte-aligned fetch to instruction memory at a time. Each returned 64-bit word is split into a way0/way1 instruction pair and pushed into the per-way instruction/address buffers using their valid/ready handshake. It also handles redirects (jumps), including discarding responses that are still in flight.

---
 rtl/inst_fetch_pc_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_pc_gen.sv
// Fetch-request front end for the dual-way fetch path.
// Owns the program counter and keeps at most one 8-byte fetch in flight.
// Each returned 64-bit word is pushed as a way0/way1 pair once both per-way
// buffers are ready. Redirects take priority in every state, and a response
// still in flight at redirect time is discarded.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no request outstanding; issue fetch of {pc,000} unless jumping
// WAIT  | one request outstanding; its response is wanted
// HOLD  | response captured, waiting for both way buffers to be ready
// DROP  | one request outstanding whose response is stale; discard it
module inst_fetch_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        jumpFlag_i,
   input  logic [31:0] jumpAddr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [63:0] imem_rdata_i,
   input  logic        way0_ready_i,
   input  logic        way1_ready_i,
   output logic        way0_valid_o,
   output logic [31:0] way0_inst_o,
   output logic [31:0] way0_instAddr_o,
   output logic        way1_valid_o,
   output logic [31:0] way1_inst_o,
   output logic [31:0] way1_instAddr_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [28:0] pc_q;
   logic        skip0_q;
   logic [63:0] hold_data_q;
   logic        hold_skip0_q;

   logic        both_ready;
   logic        deliver;
   logic        capture;
   logic [63:0] dlv_data;
   logic        dlv_skip0;

   // Jump targets are word aligned, so the two low bits carry no information.
   logic        unused_jump_lsbs;
   assign unused_jump_lsbs = ^jumpAddr_i[1:0];

   assign both_ready  = way0_ready_i & way1_ready_i;
   assign imem_addr_o = {pc_q, 3'b000};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a jump overrides any delivery or capture.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!jumpFlag_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (jumpFlag_i)         state_d = imem_rvalid_i ? S_IDLE : S_DROP;
            else if (imem_rvalid_i) state_d = both_ready ? S_IDLE : S_HOLD;
         end
         S_HOLD: begin
            if (jumpFlag_i || both_ready) state_d = S_IDLE;
         end
         S_DROP: begin
            if (imem_rvalid_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: request strobe, deliver/capture strobes and data source.
   always_comb begin
      imem_req_o = 1'b0;
      deliver    = 1'b0;
      capture    = 1'b0;
      dlv_data   = imem_rdata_i;
      dlv_skip0  = skip0_q;
      case (state_q)
         S_IDLE: begin
            imem_req_o = ~jumpFlag_i & ~reset;
         end
         S_WAIT: begin
            if (imem_rvalid_i && !jumpFlag_i) begin
               deliver = both_ready;
               capture = ~both_ready;
            end
         end
         S_HOLD: begin
            dlv_data  = hold_data_q;
            dlv_skip0 = hold_skip0_q;
            deliver   = both_ready & ~jumpFlag_i;
         end
         default: ;
      endcase
   end

   // Program counter, hold buffer and registered way outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q            <= RESET_PC[31:3];
         skip0_q         <= 1'b0;
         hold_data_q     <= '0;
         hold_skip0_q    <= 1'b0;
         way0_valid_o    <= 1'b0;
         way1_valid_o    <= 1'b0;
         way0_inst_o     <= '0;
         way1_inst_o     <= '0;
         way0_instAddr_o <= '0;
         way1_instAddr_o <= '0;
      end else begin
         way0_valid_o <= deliver & ~dlv_skip0;
         way1_valid_o <= deliver;
         if (jumpFlag_i) begin
            pc_q    <= jumpAddr_i[31:3];
            skip0_q <= jumpAddr_i[2];
         end else if (deliver) begin
            pc_q    <= pc_q + 29'd1;
            skip0_q <= 1'b0;
         end
         if (capture) begin
            hold_data_q  <= imem_rdata_i;
            hold_skip0_q <= skip0_q;
         end
         if (deliver) begin
            way0_inst_o     <= dlv_data[31:0];
            way1_inst_o     <= dlv_data[63:32];
            way0_instAddr_o <= {pc_q, 3'b000};
            way1_instAddr_o <= {pc_q, 3'b100};
         end
      end
   end

endmodule
